// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq -- multi-byte stack transfer sequencer
//
// Moves a 2-byte (pc22b=0) or 3-byte (pc22b=1) return address between the
// requester and stack RAM, one byte per enabled cycle. It uses the register
// file's SP (sph_in:spl_in) as the RAM address and drives sp_en/sp_ndown_up
// so that the register file post-decrements on push and pre-increments on pop.
//
// Ports
//   cp2, ireset        clock, async active-low reset
//   cp2en              clock enable; FSM, capture regs and strobes qualified
//   push_req, pop_req  start requests, sampled in IDLE only (push wins)
//   push_data          address to push, latched at acceptance
//   pop_data           popped address, updated whole at the end of a pop
//   busy, done         transfer in progress / one-cycle completion pulse
//   spl_in, sph_in     current SP from the register file
//   sp_en, sp_ndown_up SP count enable and direction (1 = increment)
//   ram_adr            stack RAM address (always SP)
//   ram_we, ram_re     RAM write / read strobes
//   ram_dout, ram_din  RAM write data / read data (one cycle after ram_re)
// -----------------------------------------------------------------------------
module stack_seq #(
   parameter bit pc22b = 1'b0
) (
   input  logic        cp2,
   input  logic        ireset,
   input  logic        cp2en,
   input  logic        push_req,
   input  logic        pop_req,
   input  logic [21:0] push_data,
   output logic [21:0] pop_data,
   output logic        busy,
   output logic        done,
   input  logic [7:0]  spl_in,
   input  logic [7:0]  sph_in,
   output logic        sp_en,
   output logic        sp_ndown_up,
   output logic [15:0] ram_adr,
   output logic        ram_we,
   output logic        ram_re,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din
);

   // Index of the last byte of a transfer (N-1).
   localparam logic [1:0] LAST = pc22b ? 2'd2 : 2'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_B0,
      S_PUSH_B1,
      S_PUSH_B2,
      S_POP_INC,
      S_POP_RD,
      S_POP_FIN,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [21:0] push_q,  push_d;
   logic [21:0] pop_q,   pop_d;
   logic [1:0]  cnt_q,   cnt_d;
   // Popped bytes arrive MSB first; shifting them in from the bottom leaves
   // them in place once the final byte 0 is appended at POP_FIN. 14 bits hold
   // at most byte 2 (6 significant bits) followed by byte 1.
   logic [13:0] pend_q,  pend_d;

   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset) begin
         state_q <= S_IDLE;
         push_q  <= '0;
         pop_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         push_q  <= push_d;
         pop_q   <= pop_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Next state and datapath updates; everything holds while cp2en = 0.
   always_comb begin
      state_d = state_q;
      push_d  = push_q;
      pop_d   = pop_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      if (cp2en) begin
         case (state_q)
            S_IDLE: begin
               if (push_req) begin
                  state_d = S_PUSH_B0;
                  push_d  = pc22b ? push_data : {6'b0, push_data[15:0]};
               end else if (pop_req) begin
                  state_d = S_POP_INC;
                  cnt_d   = '0;
                  pend_d  = '0;
               end
            end
            S_PUSH_B0: state_d = S_PUSH_B1;
            S_PUSH_B1: state_d = (LAST == 2'd2) ? S_PUSH_B2 : S_DONE;
            S_PUSH_B2: state_d = S_DONE;
            S_POP_INC: begin
               // A nonzero count means the previous POP_RD left a byte on ram_din.
               if (cnt_q != 2'd0) pend_d = {pend_q[5:0], ram_din};
               state_d = S_POP_RD;
            end
            S_POP_RD: begin
               cnt_d   = cnt_q + 2'd1;
               state_d = (cnt_q == LAST) ? S_POP_FIN : S_POP_INC;
            end
            S_POP_FIN: begin
               pop_d   = {pend_q, ram_din};
               state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Strobes and outputs decoded from the current state.
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      sp_en       = 1'b0;
      sp_ndown_up = 1'b0;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      ram_dout    = 8'h00;
      case (state_q)
         S_PUSH_B0: begin
            busy     = 1'b1;
            sp_en    = cp2en;
            ram_we   = cp2en;
            ram_dout = push_q[7:0];
         end
         S_PUSH_B1: begin
            busy     = 1'b1;
            sp_en    = cp2en;
            ram_we   = cp2en;
            ram_dout = push_q[15:8];
         end
         S_PUSH_B2: begin
            busy     = 1'b1;
            sp_en    = cp2en;
            ram_we   = cp2en;
            ram_dout = {2'b00, push_q[21:16]};
         end
         S_POP_INC: begin
            busy        = 1'b1;
            sp_en       = cp2en;
            sp_ndown_up = 1'b1;
         end
         S_POP_RD: begin
            busy   = 1'b1;
            ram_re = cp2en;
         end
         S_POP_FIN: busy = 1'b1;
         S_DONE:    done = cp2en;
         default: ;
      endcase
   end

   assign ram_adr  = {sph_in, spl_in};
   assign pop_data = pop_q;

endmodule

// File: tb/tb_stack_seq.sv
module tb_stack_seq;

   logic        cp2 = 1'b0;
   logic        ireset;
   logic        cp2en;
   logic [1:0]  push_req, pop_req;
   logic [21:0] push_data;
   logic [21:0] popd [2];
   logic [1:0]  busy, done, sp_en, upd, we, re;
   logic [15:0] adr  [2];
   logic [7:0]  dout [2];
   logic [7:0]  rdat [2];

   // Register-file SP and RAM environment
   logic [15:0] sp [2];
   logic [1:0]  sp_ld;
   logic [15:0] sp_val;
   logic [7:0]  mem [0:65535];
   logic [31:0] rd_log;

   int ntests = 0;
   int nfail  = 0;
   int nb, da, nd, vi;

   always #5 cp2 = ~cp2;

   stack_seq #(.pc22b(1'b0)) u0 (
      .cp2(cp2), .ireset(ireset), .cp2en(cp2en),
      .push_req(push_req[0]), .pop_req(pop_req[0]), .push_data(push_data),
      .pop_data(popd[0]), .busy(busy[0]), .done(done[0]),
      .spl_in(sp[0][7:0]), .sph_in(sp[0][15:8]),
      .sp_en(sp_en[0]), .sp_ndown_up(upd[0]), .ram_adr(adr[0]),
      .ram_we(we[0]), .ram_re(re[0]), .ram_dout(dout[0]), .ram_din(rdat[0]));

   stack_seq #(.pc22b(1'b1)) u1 (
      .cp2(cp2), .ireset(ireset), .cp2en(cp2en),
      .push_req(push_req[1]), .pop_req(pop_req[1]), .push_data(push_data),
      .pop_data(popd[1]), .busy(busy[1]), .done(done[1]),
      .spl_in(sp[1][7:0]), .sph_in(sp[1][15:8]),
      .sp_en(sp_en[1]), .sp_ndown_up(upd[1]), .ram_adr(adr[1]),
      .ram_we(we[1]), .ram_re(re[1]), .ram_dout(dout[1]), .ram_din(rdat[1]));

   always @(posedge cp2) begin
      for (int k = 0; k < 2; k++) begin
         if (sp_ld[k])      sp[k] <= sp_val;
         else if (sp_en[k]) sp[k] <= upd[k] ? sp[k] + 16'd1 : sp[k] - 16'd1;
         if (we[k]) mem[adr[k]] <= dout[k];
         if (re[k]) rdat[k] <= mem[adr[k]];
      end
      if (re[0]) rd_log <= {rd_log[15:0], adr[0]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic set_sp(input int i, input logic [15:0] v);
      @(negedge cp2);
      sp_val   = v;
      sp_ld[i] = 1'b1;
      @(negedge cp2);
      sp_ld[i] = 1'b0;
   endtask

   // Issue a request, then watch up to 40 cycles: busy cycles, first done
   // cycle, number of done cycles, strobes seen while cp2en = 0.
   task automatic xfer(input int i, input bit push, input bit pop, input logic [21:0] d,
                       input bit stall, input int pop_hold,
                       output int nbusy, output int done_at, output int ndone, output int viol);
      @(negedge cp2);
      cp2en       = 1'b1;
      push_data   = d;
      push_req[i] = push;
      pop_req[i]  = pop;
      @(posedge cp2);
      #1;
      push_req[i] = 1'b0;
      if (pop_hold == 0) pop_req[i] = 1'b0;
      nbusy = 0; done_at = 0; ndone = 0; viol = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge cp2);
         if (stall) cp2en = ~cp2en;
         pop_req[i] = (c <= pop_hold) ? pop : 1'b0;
         #1;
         if (busy[i]) nbusy++;
         if (done[i]) begin
            ndone++;
            if (done_at == 0) done_at = c;
         end
         if (!cp2en && (sp_en[i] | we[i] | re[i] | done[i])) viol++;
         if (done_at != 0 && c >= done_at + 2) break;
      end
      cp2en = 1'b1;
   endtask

   initial begin
      ireset = 1'b0; cp2en = 1'b1;
      push_req = '0; pop_req = '0; push_data = '0;
      sp_ld = '0; sp_val = '0; rd_log = '0;
      #23;
      // Reset state
      chk("rst_busy",  {30'd0, busy}, 32'd0);
      chk("rst_done",  {30'd0, done}, 32'd0);
      chk("rst_pop0",  {10'd0, popd[0]}, 32'd0);
      chk("rst_pop1",  {10'd0, popd[1]}, 32'd0);
      chk("rst_strb",  {26'd0, sp_en, we, re}, 32'd0);
      @(negedge cp2);
      ireset = 1'b1;

      // 2-byte push; upper bits of push_data must be dropped
      set_sp(0, 16'h10FF);
      xfer(0, 1, 0, 22'h3F1234, 0, 0, nb, da, nd, vi);
      chk("push2_busy", nb, 2);
      chk("push2_done", da, 3);
      chk("push2_ndone", nd, 1);
      chk("push2_m10ff", {24'd0, mem[16'h10FF]}, 32'h34);
      chk("push2_m10fe", {24'd0, mem[16'h10FE]}, 32'h12);
      chk("push2_sp", {16'd0, sp[0]}, 32'h10FD);

      // 2-byte pop
      xfer(0, 0, 1, 22'h0, 0, 0, nb, da, nd, vi);
      chk("pop2_busy", nb, 5);
      chk("pop2_done", da, 6);
      chk("pop2_data", {10'd0, popd[0]}, 32'h001234);
      chk("pop2_sp", {16'd0, sp[0]}, 32'h10FF);
      chk("pop2_rdadr", rd_log, 32'h10FE10FF);

      // 3-byte push and pop
      set_sp(1, 16'h0200);
      xfer(1, 1, 0, 22'h3ABCDE, 0, 0, nb, da, nd, vi);
      chk("push3_busy", nb, 3);
      chk("push3_done", da, 4);
      chk("push3_m0200", {24'd0, mem[16'h0200]}, 32'hDE);
      chk("push3_m01ff", {24'd0, mem[16'h01FF]}, 32'hBC);
      chk("push3_m01fe", {24'd0, mem[16'h01FE]}, 32'h3A);
      chk("push3_sp", {16'd0, sp[1]}, 32'h01FD);
      xfer(1, 0, 1, 22'h0, 0, 0, nb, da, nd, vi);
      chk("pop3_busy", nb, 7);
      chk("pop3_done", da, 8);
      chk("pop3_data", {10'd0, popd[1]}, 32'h3ABCDE);
      chk("pop3_sp", {16'd0, sp[1]}, 32'h0200);

      // Stalled pop: cp2en toggles every cycle
      set_sp(0, 16'h2000);
      xfer(0, 1, 0, 22'h00A55A, 0, 0, nb, da, nd, vi);
      chk("stl_pre_sp", {16'd0, sp[0]}, 32'h1FFE);
      xfer(0, 0, 1, 22'h0, 1, 0, nb, da, nd, vi);
      chk("stl_busy", nb, 10);
      chk("stl_done", da, 12);
      chk("stl_ndone", nd, 1);
      chk("stl_viol", vi, 0);
      chk("stl_data", {10'd0, popd[0]}, 32'h00A55A);
      chk("stl_sp", {16'd0, sp[0]}, 32'h2000);

      // Arbitration: push+pop together, pop held through busy and done
      set_sp(0, 16'h3000);
      xfer(0, 1, 1, 22'h000777, 0, 3, nb, da, nd, vi);
      chk("arb_busy", nb, 2);
      chk("arb_done", da, 3);
      chk("arb_m3000", {24'd0, mem[16'h3000]}, 32'h77);
      chk("arb_m2fff", {24'd0, mem[16'h2FFF]}, 32'h07);
      chk("arb_sp", {16'd0, sp[0]}, 32'h2FFE);
      chk("arb_popkeep", {10'd0, popd[0]}, 32'h00A55A);

      // Reset in the middle of a 3-byte pop (first POP_RD)
      @(negedge cp2);
      pop_req[1] = 1'b1;
      @(posedge cp2);
      #1 pop_req[1] = 1'b0;
      @(negedge cp2);
      @(negedge cp2);
      #1;
      chk("mid_re", {31'd0, re[1]}, 32'd1);
      ireset = 1'b0;
      #1;
      chk("mid_busy", {31'd0, busy[1]}, 32'd0);
      chk("mid_done", {31'd0, done[1]}, 32'd0);
      chk("mid_pop", {10'd0, popd[1]}, 32'd0);
      chk("mid_strb", {29'd0, sp_en[1], we[1], re[1]}, 32'd0);
      @(negedge cp2);
      ireset = 1'b1;
      chk("mid_sp", {16'd0, sp[1]}, 32'h0201);
      xfer(1, 1, 0, 22'h000055, 0, 0, nb, da, nd, vi);
      chk("post_busy", nb, 3);
      chk("post_done", da, 4);
      chk("post_m0201", {24'd0, mem[16'h0201]}, 32'h55);
      chk("post_sp", {16'd0, sp[1]}, 32'h01FE);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/stack_seq.md
# stack_seq

Sequencer for multi-byte stack transfers (CALL/RCALL/ICALL return-address push, IRQ entry push, RET/RETI pop). It sits beside the I/O register file and drives the register file's `sp_en` and `sp_ndown_up` inputs. It takes the current SPH:SPL as the stack-memory address and moves 2 bytes (16-bit PC) or 3 bytes (22-bit PC) between the requester and data RAM, one byte per step. The requester sees a single request/busy/done handshake.

## Interface
- `pc22b`, default 0; 0 = 2-byte PC transfers, 1 = 3-byte PC transfers.
- `cp2`  in  1  core clock.
- `ireset`  in  1  reset, asynchronous, active-low.
- `cp2en`  in  1  clock enable; the FSM and all strobes are qualified by it.
- `push_req`  in  1  start a push; sampled in IDLE only.
- `pop_req`  in  1  start a pop; sampled in IDLE only.
- `push_data`  in  22  return address to push; latched at acceptance.
- `pop_data`  out  22  assembled popped address; holds its value until the next pop completes.
- `busy`  out  1  a transfer is in progress.
- `done`  out  1  one-cycle completion pulse.
- `spl_in`, `sph_in`  in  8 each  current SP from the register file.
- `sp_en`  out  1  SP count enable to the register file.
- `sp_ndown_up`  out  1  SP direction: 0 = decrement, 1 = increment.
- `ram_adr`  out  16  stack RAM address; equals {sph_in, spl_in} in every active state.
- `ram_we`, `ram_re`  out  1 each  RAM write and read strobes.
- `ram_dout`  out  8  write data.
- `ram_din`  in  8  read data; valid in the cycle after `ram_re`.

## Operation
- N = 2 bytes when `pc22b` = 0 and N = 3 bytes when `pc22b` = 1. With `pc22b` = 0, `push_data[21:16]` is ignored and `pop_data[21:16]` reads 0.
- States:
  - IDLE
  - PUSH_B0 … PUSH_B(N-1)
  - POP_INC, POP_RD, POP_FIN
  - DONE
- IDLE:
  - `push_req` = 1 → PUSH_B0; `push_data` is latched.
  - else `pop_req` = 1 → POP_INC; the byte counter is cleared.
  - Simultaneous requests: push wins; the pop request is ignored and must be reasserted.
- PUSH_Bk:
  - `ram_we` = 1, `ram_dout` = byte k (byte 0 = bits 7:0, byte 1 = 15:8, byte 2 = 21:16).
  - `sp_en` = 1, `sp_ndown_up` = 0. The register file decrements SP at the same edge that writes RAM, per AVR post-decrement push.
  - After the last byte → DONE.
- POP_INC: `sp_en` = 1, `sp_ndown_up` = 1 (pre-increment). If a read is outstanding from the previous POP_RD, `ram_din` is captured into the pending byte slot. → POP_RD.
- POP_RD: `ram_re` = 1; the counter advances. If bytes remain → POP_INC, else → POP_FIN.
- POP_FIN: captures the final `ram_din`. → DONE.
- Pop byte order: the first byte popped is the most significant (byte N-1), and the last byte popped is byte 0. `pop_data` is updated as a whole at POP_FIN, so a partial value is never visible.
- DONE: `done` = 1, `busy` = 0. → IDLE. `push_req`/`pop_req` are not sampled in DONE.
- `busy` = 1 in all PUSH and POP states.
- `push_req`/`pop_req` are ignored outside IDLE; no queuing.
- `sp_en`, `ram_we`, `ram_re` and `done` are ANDed with `cp2en`. When `cp2en` = 0 the FSM, counter and capture registers hold and no strobe is issued. Every state therefore lasts exactly one enabled cycle.
- In IDLE and DONE: `sp_en` = 0, `sp_ndown_up` = 0, `ram_we` = 0, `ram_re` = 0, `ram_adr` = SP, `ram_dout` = 0.

## Timing
- Reset (async, `ireset` = 0):
  - FSM → IDLE.
  - `pop_data` = 0, the push latch = 0, the counter = 0.
  - All strobes, `busy` and `done` = 0.
  - Reset mid-transfer aborts immediately. Whatever SP updates and RAM writes already happened are not undone.
- Push latency (enabled cycles from acceptance edge): N busy cycles, then a `done` cycle. New request accepted at the earliest 1 cycle after `done`.
- Pop latency: 2N + 1 busy cycles (INC/RD pairs plus FIN), then a `done` cycle.
- RAM read is synchronous, one cycle of latency. The capture cycle's `ram_adr` is irrelevant to that read.
- SP arithmetic is 16-bit and wraps in the register file: 0x0000 − 1 = 0xFFFF. This block does no bounds checking.
- Required ordering with the register file: SP must not be written via I/O while `busy` = 1. The core guarantees this.

## Test plan
- Push, `pc22b` = 0: SP = 0x10FF, `push_data` = 0x001234.
  - Cycle 1 → RAM[0x10FF] = 0x34; cycle 2 → RAM[0x10FE] = 0x12.
  - SP = 0x10FD, `done` pulse in cycle 3, `busy` high for exactly 2 cycles.
- Pop, `pc22b` = 0: SP = 0x10FD with the RAM contents above.
  - Reads at 0x10FE then 0x10FF; `pop_data` = 0x001234; SP = 0x10FF.
  - `busy` high 5 cycles, `done` in cycle 6.
- `pc22b` = 1: push 0x3ABCDE at SP = 0x0200.
  - RAM[0x0200] = 0xDE, RAM[0x01FF] = 0xBC, RAM[0x01FE] = 0x3A; SP = 0x01FD.
  - A following pop returns `pop_data` = 0x3ABCDE and SP = 0x0200.
- Stall: toggle `cp2en` 1/0 every cycle during a pop.
  - Same RAM/SP results as the unstalled pop; no strobe is asserted while `cp2en` = 0.
  - Latency doubles; `done` is one enabled cycle long.
- Arbitration: `push_req` and `pop_req` both high in IDLE → push executes; the pop is ignored. A `pop_req` asserted while `busy` = 1 is ignored.
- Reset mid-pop: assert `ireset` = 0 during POP_RD of byte 2.
  - `busy`, `done`, `pop_data` and all strobes read 0 immediately.
  - After release, the block is in IDLE and accepts a new push.
